pcm_interp_upsampler: RTL and testbench



---
 rtl/pcm_interp_upsampler_pkg.sv | 21 ++
 rtl/pcm_interp_upsampler_if.sv | 36 +++
 rtl/pcm_interp_upsampler_fifo.sv | 67 ++++++
 rtl/pcm_interp_upsampler.sv | 142 ++++++++++++++
 tb/tb_pcm_interp_upsampler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pcm_interp_upsampler_pkg.sv
// Shared types and helpers for the PCM linear-interpolation upsampler.
// Pure declarations: no logic, no latency.
// Not applicable: no flow control lives here.
package pcm_interp_pkg;

    localparam int PCM_W = 16;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic signed [PCM_W:0]   delta_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift amount that turns a product with k in 0..OSR-1 into a fraction of delta.
    function automatic int calc_s(input int osr);
        return $clog2(osr);
    endfunction

endpackage

// File: rtl/pcm_interp_upsampler_if.sv
// Bundles the PCM input handshake and oversampled output strobe of the upsampler.
// Wiring only: no latency.
// Input side is valid/ready; output side is a strobe with no backpressure.
// Signals: valid_in/din/ready_in (audio-rate input), valid_out/dout (oversampled output),
//          underrun (one-cycle pulse when a segment boundary finds no new sample).
interface pcm_interp_upsampler_if;
    import pcm_interp_pkg::*;

    logic valid_in;
    pcm_t din;
    logic ready_in;
    logic valid_out;
    pcm_t dout;
    logic underrun;

    // Audio source side.
    modport master (
        output valid_in,
        output din,
        input  ready_in,
        input  valid_out,
        input  dout,
        input  underrun
    );

    // Upsampler side.
    modport slave (
        input  valid_in,
        input  din,
        output ready_in,
        output valid_out,
        output dout,
        output underrun
    );

endinterface

// File: rtl/pcm_interp_upsampler_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// Write visible on dout one cycle after push; pop consumes the current head.
// full/empty come from the registered count; a push while full is dropped even if a pop occurs.
// Ports: clk, rst_n, push/din (write), pop/dout (read head), full, empty.
module pcm_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pcm_interp_upsampler.sv
// Linear-interpolating PCM upsampler: OSR output samples per input, one every TICK_DIV clocks.
// Output registered: dout/valid_out appear the cycle after each internal tick.
// Input stalls via ready_in when the FIFO is full; the output never stalls, underrun repeats the last sample.
// Ports: clk, rst_n (async active-low), bus (slave modport: valid_in/din/ready_in in,
//        valid_out/dout/underrun out).
module pcm_interp_upsampler
    import pcm_interp_pkg::*;
#(
    parameter int OSR        = 64,
    parameter int TICK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pcm_interp_upsampler_if.slave  bus
);

    localparam int S  = calc_s(OSR);
    localparam int TW = $clog2(TICK_DIV);

    localparam logic [S-1:0]  K_LAST    = S'(OSR - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [S-1:0]  k_q, k_d;
    pcm_t          prev_q, prev_d;
    pcm_t          cur_q, cur_d;
    pcm_t          dout_q, dout_d;
    logic          valid_out_q, valid_out_d;
    logic          underrun_q, underrun_d;

    logic             fifo_pop;
    logic [PCM_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    pcm_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.valid_in),
        .pop   (fifo_pop),
        .din   (bus.din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Interpolation: prev + floor((cur - prev) * k / OSR).
    // The result always lies between prev and cur, so the 17-bit sum fits back into 16 bits.
    delta_t              delta;
    logic signed [16+S:0] delta_w;
    logic signed [16+S:0] k_w;
    logic signed [16+S:0] prod;
    pcm_t                interp;

    assign delta   = delta_t'(cur_q) - delta_t'(prev_q);
    assign delta_w = {{S{delta[16]}}, delta};
    assign k_w     = {17'd0, k_q};
    assign prod    = delta_w * k_w;
    assign interp  = pcm_t'(delta_t'(prev_q) + delta_t'(prod >>> S));

    logic tick;
    assign tick = (state_q == RUN) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        k_d         = k_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        dout_d      = dout_q;
        valid_out_d = 1'b0;
        underrun_d  = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = pcm_t'(fifo_dout);
                    prev_d   = '0;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
                if (tick) begin
                    dout_d      = interp;
                    valid_out_d = 1'b1;
                    if (k_q != K_LAST) begin
                        k_d = k_q + S'(1);
                    end else begin
                        k_d    = '0;
                        prev_d = cur_q;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            cur_d    = pcm_t'(fifo_dout);
                        end else begin
                            // cur stays put, so the next segment is flat at the last sample.
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            k_q         <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            k_q         <= k_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            dout_q      <= dout_d;
            valid_out_q <= valid_out_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.ready_in  = !fifo_full;
    assign bus.valid_out = valid_out_q;
    assign bus.dout      = dout_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_pcm_interp_upsampler.sv
// Directed bench for pcm_interp_upsampler with OSR=4, TICK_DIV=2, FIFO_DEPTH=4.
module tb_pcm_interp_upsampler;
    import pcm_interp_pkg::*;

    localparam int OSR        = 4;
    localparam int TICK_DIV   = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pcm_interp_upsampler_if bus ();

    pcm_interp_upsampler #(
        .OSR        (OSR),
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int got[$];
    int stamp[$];
    int ur_pos[$];

    typedef struct {
        int a;
        int b;
        int exp[12];
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, then the caller may drive inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.valid_out === 1'b1) begin
            got.push_back(int'(bus.dout));
            stamp.push_back(cyc);
        end
        if (bus.underrun === 1'b1) ur_pos.push_back(got.size());
    endtask

    function automatic int g(input int i);
        if (i < got.size()) return got[i];
        return 99999;
    endfunction

    function automatic int u(input int i);
        if (i < ur_pos.size()) return ur_pos[i];
        return -1;
    endfunction

    task automatic clear_log();
        got.delete();
        stamp.delete();
        ur_pos.delete();
        cyc = 0;
    endtask

    task automatic do_reset(input string tag);
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.din      = '0;
        step();
        step();
        chk({tag, "_rst_ready"},    int'(bus.ready_in),  1);
        chk({tag, "_rst_valid"},    int'(bus.valid_out), 0);
        chk({tag, "_rst_dout"},     int'(bus.dout),      0);
        chk({tag, "_rst_underrun"}, int'(bus.underrun),  0);
        rst_n = 1'b1;
        clear_log();
    endtask

    // Hold valid_in until accepted; report cycles spent blocked and strobes seen when accepted.
    task automatic push_sample(input int v, output int waited, output int seen);
        bus.valid_in = 1'b1;
        bus.din      = 16'(v);
        waited       = 0;
        seen         = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.ready_in === 1'b1) begin
                seen = got.size();
                step();
                bus.valid_in = 1'b0;
                return;
            end
            waited++;
            step();
        end
        bus.valid_in = 1'b0;
        chk("push_timeout", waited, 0);
    endtask

    task automatic collect(input int n);
        for (int c = 0; c < 400 && got.size() < n; c++) step();
        if (got.size() < n) chk("collect_timeout", got.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int w;
        int s;
        int bad;

        // Segment 1 ramps from 0 to a, segment 2 from a to b, segment 3 is flat at b (underrun).
        vecs[0].a = 0;     vecs[0].b = 400;
        vecs[0].exp = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 400, 400, 400};
        vecs[1].a = 400;   vecs[1].b = -400;
        vecs[1].exp = '{0, 100, 200, 300, 400, 200, 0, -200, -400, -400, -400, -400};
        vecs[2].a = 0;     vecs[2].b = -1;
        vecs[2].exp = '{0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1, -1};
        vecs[3].a = 32767; vecs[3].b = -32768;
        vecs[3].exp = '{0, 8191, 16383, 24575, 32767, 16383, -1, -16385, -32768, -32768, -32768, -32768};

        bus.valid_in = 1'b0;
        bus.din      = '0;

        for (int v = 0; v < 4; v++) begin
            do_reset($sformatf("vec%0d", v));
            push_sample(vecs[v].a, w, s);
            push_sample(vecs[v].b, w, s);
            collect(12);
            for (int i = 0; i < 12; i++)
                chk($sformatf("vec%0d_sample%0d", v, i), g(i), vecs[v].exp[i]);
            bad = 0;
            for (int i = 1; i < stamp.size(); i++)
                if (stamp[i] - stamp[i-1] != TICK_DIV) bad++;
            chk($sformatf("vec%0d_strobe_gaps", v), bad, 0);
            chk($sformatf("vec%0d_underrun_count", v), ur_pos.size(), 2);
            chk($sformatf("vec%0d_underrun_pos0", v), u(0), 8);
            chk($sformatf("vec%0d_underrun_pos1", v), u(1), 12);
        end

        // Backpressure: six samples offered back to back, the sixth must wait for the first boundary pop.
        do_reset("bp");
        for (int i = 1; i <= 5; i++) push_sample(400 * i, w, s);
        chk("bp_full_after_5", int'(bus.ready_in), 0);
        push_sample(2400, w, s);
        chk("bp_sixth_blocked", int'(w > 0), 1);
        chk("bp_ready_returns_at_boundary", s, 4);
        chk("bp_full_again", int'(bus.ready_in), 0);
        collect(24);
        for (int i = 0; i < 24; i++) chk($sformatf("bp_sample%0d", i), g(i), 100 * i);
        chk("bp_underrun_count", ur_pos.size(), 1);
        chk("bp_underrun_pos", u(0), 24);

        // Underrun: single sample, then repeated flat segments with a pulse at every boundary.
        do_reset("ur");
        push_sample(100, w, s);
        collect(12);
        for (int i = 0; i < 12; i++) chk($sformatf("ur_sample%0d", i), g(i), (i < 4) ? 25 * i : 100);
        chk("ur_count", ur_pos.size(), 3);
        chk("ur_pos0", u(0), 4);
        chk("ur_pos1", u(1), 8);
        chk("ur_pos2", u(2), 12);

        // Reset mid-segment with two entries queued: immediate clear, then IDLE until new input.
        do_reset("mid");
        push_sample(400, w, s);
        push_sample(800, w, s);
        push_sample(1200, w, s);
        collect(2);
        chk("mid_pre_reset_dout", int'(bus.dout), 100);
        rst_n = 1'b0;
        #1;
        chk("mid_async_dout",     int'(bus.dout),      0);
        chk("mid_async_ready",    int'(bus.ready_in),  1);
        chk("mid_async_valid",    int'(bus.valid_out), 0);
        chk("mid_async_underrun", int'(bus.underrun),  0);
        step();
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 20; i++) step();
        chk("mid_idle_no_strobes",  got.size(),    0);
        chk("mid_idle_no_underrun", ur_pos.size(), 0);
        push_sample(400, w, s);
        collect(4);
        for (int i = 0; i < 4; i++) chk($sformatf("mid_restart_sample%0d", i), g(i), 100 * i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
